hamming84_tx_sched: RTL
=======================

// Module: hamming84_tx_sched
// PURPOSE
//  Shares one hamming84_enc instance among NCH byte-wide requesters on the
//  transmit side of the pflink. A round-robin arbiter grants one byte at a time.
//  The byte is split into low and high nibbles, and each nibble is emitted as one
//  8-bit SECDED codeword on a valid/ready stream tagged with the source channel.
//  The block sits between the per-channel TX sources and the link serializer.
// PARAMETERS
//  NCH   4  number of requester channels (2..16)
//  CH_W  $clog2(NCH) (localparam)  width of the channel tag
// PORTS
//  clk        in   1        system clock
//  rst_n      in   1        asynchronous, active-low reset
//  req_valid  in   NCH      per-channel byte valid
//  req_data   in   8*NCH    per-channel byte; channel i = [8*i+7:8*i]
//  req_ready  out  NCH      one-hot accept; a byte transfers when valid&ready
//  out_valid  out  1        codeword valid
//  out_code   out  8        hamming84 codeword
//  out_ch     out  CH_W     channel that owns the codeword
//  out_last   out  1        0 = low-nibble codeword, 1 = high-nibble codeword
//  out_ready  in   1        downstream accept
//  byte_cnt   out  16       bytes fully sent (high nibble handshaken), wraps
// BEHAVIOUR
//  - One clock, asynchronous active-low reset.
//  - Reset values: state=IDLE, out_valid=0, out_code=0, out_ch=0, out_last=0,
//    byte_cnt=0, last_grant=NCH-1 (channel 0 has first priority), req_ready=0.
//  - FSM states: IDLE, LO, HI.
//  - IDLE: if any req_valid, grant the first valid channel searching from
//    last_grant+1 mod NCH. Assert req_ready[g] combinationally in the same cycle,
//    register the byte and g, set last_grant=g, and go to LO. Otherwise stay in IDLE.
//  - LO: out_valid=1, out_code=enc(byte[3:0]), out_last=0. On out_ready, go to HI.
//  - HI: out_valid=1, out_code=enc(byte[7:4]), out_last=1. On out_ready:
//    byte_cnt+=1. If any req_valid, grant the next channel as in IDLE
//    (req_ready[g] is asserted in this same cycle) and go to LO; otherwise go to IDLE.
//  - Peak throughput is 1 byte per 2 cycles with no idle bubble.
//  - req_ready depends combinationally on out_ready, in HI state only.
//  - Outputs (out_code, out_ch, out_last, out_valid) are stable while
//    out_valid=1 and out_ready=0. A granted byte is never dropped or reordered.
//  - A requester dropping req_valid before being granted is legal; it is not
//    granted. Once granted, the byte is owned by this block.
//  - out_code comes from a registered nibble through a combinational encoder.
//    Latency from byte accept to first out_valid is 1 cycle.
//  - byte_cnt is 16-bit unsigned and wraps 0xFFFF -> 0x0000.
//  - Reset mid-operation aborts the in-flight byte. No partial codeword pair is
//    resumed after reset.
// CONFIGURATION
//  HAMMING84_TX_ERR_INJECT_EN defined:
//   - Extra ports inj_req (in, 1) and inj_bit (in, 3).
//   - inj_req=1 arms a one-shot and latches inj_bit. Re-arming while armed
//     re-latches inj_bit.
//   - The next codeword handshake (out_valid&out_ready) emits out_code with bit
//     inj_bit inverted, and the one-shot clears on that handshake.
//   - The armed flag resets to 0.
//  HAMMING84_TX_ERR_INJECT_EN undefined: the extra ports and logic are absent,
//   and out_code is always the clean encoding.
// TESTING
//  - Reset: hold rst_n=0 -> out_valid=0, req_ready=0, byte_cnt=0. Release with
//    no req_valid -> state stays IDLE.
//  - Single byte: ch0 sends 0xA5, out_ready=1 -> out_code 0x2D/out_last=0, then
//    0xD2/out_last=1, out_ch=0, byte_cnt=1.
//  - Round-robin: all 4 channels valid continuously -> grant order 0,1,2,3,0.
//    Bytes 0x00 and 0xFF encode to 0x00,0x00 and 0xFF,0xFF.
//  - Backpressure: out_ready=0 for 5 cycles in LO -> out_code/out_ch held and
//    no req_ready asserted. On release, HI follows.
//  - Reset mid-op: assert rst_n=0 in HI -> out_valid=0 asynchronously. After
//    release, the aborted byte is not emitted.
//  - Injection (macro on): inj_req with inj_bit=0, then byte 0xA5 -> codewords
//    0x2C then 0xD2. byte_cnt preset via 65535 bytes wraps to 0.

Source files
------------

// File: rtl/hamming84_tx_sched.sv
// Round-robin scheduler sharing one Hamming(8,4) SECDED encoder among NCH byte requesters.
// Optional HAMMING84_TX_ERR_INJECT_EN adds a one-shot single-bit error injector on out_code.
module hamming84_tx_sched #(
   parameter  int unsigned NCH  = 4,
   localparam int unsigned CH_W = $clog2(NCH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NCH-1:0]     req_valid,
   input  logic [8*NCH-1:0]   req_data,
   output logic [NCH-1:0]     req_ready,
   output logic               out_valid,
   output logic [7:0]         out_code,
   output logic [CH_W-1:0]    out_ch,
   output logic               out_last,
   input  logic               out_ready,
   output logic [15:0]        byte_cnt
`ifdef HAMMING84_TX_ERR_INJECT_EN
   ,
   input  logic               inj_req,
   input  logic [2:0]         inj_bit
`endif
);

   typedef enum logic [1:0] {IDLE, LO, HI} state_t;

   state_t          state, state_nxt;
   logic [7:0]      data_q;
   logic [CH_W-1:0] ch_q;
   logic [CH_W-1:0] last_grant;
   logic [CH_W-1:0] gnt;
   logic [7:0]      gnt_data;
   logic            found;
   logic            take;
   logic [3:0]      nibble;
   logic [7:0]      inj_mask;

   // Codeword bits 0..6 are Hamming positions 1..7 (p1 p2 d0 p4 d1 d2 d3); bit 7 is overall parity.
   function automatic logic [7:0] enc(input logic [3:0] d);
      logic [7:0] c;
      c[0] = d[0] ^ d[1] ^ d[3];
      c[1] = d[0] ^ d[2] ^ d[3];
      c[2] = d[0];
      c[3] = d[1] ^ d[2] ^ d[3];
      c[4] = d[1];
      c[5] = d[2];
      c[6] = d[3];
      c[7] = ^c[6:0];
      return c;
   endfunction

   // Rotating priority: channels above last_grant are searched first, then wrap to the rest.
   always_comb begin
      found    = 1'b0;
      gnt      = '0;
      gnt_data = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (!found && req_valid[i] && (CH_W'(i) > last_grant)) begin
            found    = 1'b1;
            gnt      = CH_W'(i);
            gnt_data = req_data[8*i +: 8];
         end
      end
      for (int unsigned i = 0; i < NCH; i++) begin
         if (!found && req_valid[i] && (CH_W'(i) <= last_grant)) begin
            found    = 1'b1;
            gnt      = CH_W'(i);
            gnt_data = req_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               take      = 1'b1;
               state_nxt = LO;
            end
         end
         LO: begin
            if (out_ready) state_nxt = HI;
         end
         HI: begin
            if (out_ready) begin
               if (found) begin
                  take      = 1'b1;
                  state_nxt = LO;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         req_ready[i] = take && (gnt == CH_W'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         data_q     <= '0;
         ch_q       <= '0;
         last_grant <= CH_W'(NCH - 1);
         byte_cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (take) begin
            data_q     <= gnt_data;
            ch_q       <= gnt;
            last_grant <= gnt;
         end
         if (state == HI && out_ready) byte_cnt <= byte_cnt + 16'd1;
      end
   end

`ifdef HAMMING84_TX_ERR_INJECT_EN
   logic       armed;
   logic [2:0] inj_bit_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed     <= 1'b0;
         inj_bit_q <= '0;
      end else if (inj_req) begin
         armed     <= 1'b1;
         inj_bit_q <= inj_bit;
      end else if (out_valid && out_ready) begin
         armed     <= 1'b0;
      end
   end

   assign inj_mask = armed ? (8'd1 << inj_bit_q) : 8'd0;
`else
   assign inj_mask = 8'd0;
`endif

   assign out_valid = (state != IDLE);
   assign out_last  = (state == HI);
   assign out_ch    = ch_q;
   assign nibble    = (state == HI) ? data_q[7:4] : data_q[3:0];
   assign out_code  = out_valid ? (enc(nibble) ^ inj_mask) : 8'd0;

endmodule
